// File: rtl/accum_dump.sv
// rtl/accum_dump.sv - integrate-and-dump averager feeding the clip stage
//
// Purpose:
//    Sums n_avg unsigned samples, right-shifts the window sum by shift and
//    emits one saturated P_WIDTH-bit result per window with a 1-cycle strobe.
//
// Ports:
//    clk         in   clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    clr         in   synchronous clear: abort window, drop partial sum
//    n_avg       in   samples per window (0 treated as 1), latched at window start
//    shift       in   right shift applied to window sum, latched at window start
//    din_valid   in   sample qualifier
//    din         in   unsigned sample
//    dout_valid  out  1-cycle strobe, dout/dout_ovf updated
//    dout        out  averaged result, held between strobes
//    dout_ovf    out  shifted sum exceeded P_WIDTH bits, dout saturated
//
// Configuration:
//    ACCUM_DUMP_ROUND_EN  round-half-up before the shift instead of truncation

module accum_dump #(
   parameter int P_WIDTH = 16,
   parameter int P_NW    = 8,
   parameter int P_SW    = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic [P_NW-1:0]    n_avg,
   input  logic [P_SW-1:0]    shift,
   input  logic               din_valid,
   input  logic [P_WIDTH-1:0] din,
   output logic               dout_valid,
   output logic [P_WIDTH-1:0] dout,
   output logic               dout_ovf
);

   localparam int P_ACC_W = P_WIDTH + P_NW;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [P_ACC_W-1:0]   acc_q, acc_d;
   logic [P_NW-1:0]      cnt_q, cnt_d;
   logic [P_NW-1:0]      n_lat_q, n_lat_d;
   logic [P_SW-1:0]      shift_lat_q, shift_lat_d;
   logic [P_WIDTH-1:0]   dout_q, dout_d;
   logic                 dout_valid_q, dout_valid_d;
   logic                 dout_ovf_q, dout_ovf_d;

   logic                 win_start;
   logic [P_NW-1:0]      n_eff;
   logic [P_SW-1:0]      shift_eff;
   logic                 last_sample;
   logic [P_ACC_W-1:0]   sum;
   logic [P_ACC_W:0]     shifted;
   logic [P_ACC_W:0]     scaled;
   logic [P_WIDTH-1:0]   res;
   logic                 res_ovf;

   // The first sample of a window uses the live n_avg/shift so that it can
   // itself be the final sample (n==1) without waiting for the latch.
   always_comb begin
      win_start   = (state_q == IDLE);
      n_eff       = n_lat_q;
      shift_eff   = shift_lat_q;
      if (win_start) begin
         n_eff     = (n_avg == '0) ? P_NW'(1) : n_avg;
         shift_eff = shift;
      end
      last_sample = din_valid && (cnt_q == (n_eff - P_NW'(1)));
      sum         = acc_q + {{P_NW{1'b0}}, din};
   end

`ifdef ACCUM_DUMP_ROUND_EN
   localparam logic [P_ACC_W:0] ONE_X = 1;
   logic [P_ACC_W:0] rnd_sum;

   // One extra bit so adding the half-LSB can never wrap.
   always_comb begin
      rnd_sum = {1'b0, sum};
      if (shift_eff != '0) begin
         rnd_sum = {1'b0, sum} + (ONE_X << (shift_eff - P_SW'(1)));
      end
      shifted = rnd_sum >> shift_eff;
   end
`else
   always_comb begin
      shifted = {1'b0, sum >> shift_eff};
   end
`endif

   // Shifting the whole accumulator away yields 0, even if rounding would
   // otherwise carry a one back in.
   always_comb begin
      scaled = shifted;
      if (32'(shift_eff) >= P_ACC_W) begin
         scaled = '0;
      end
      res_ovf = |scaled[P_ACC_W:P_WIDTH];
      res     = res_ovf ? {P_WIDTH{1'b1}} : scaled[P_WIDTH-1:0];
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      n_lat_d      = n_lat_q;
      shift_lat_d  = shift_lat_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      dout_ovf_d   = dout_ovf_q;

      if (clr) begin
         // clr beats a coincident sample; dout/dout_ovf are left alone.
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else if (din_valid) begin
         if (win_start) begin
            n_lat_d     = n_eff;
            shift_lat_d = shift_eff;
         end
         if (last_sample) begin
            state_d      = IDLE;
            acc_d        = '0;
            cnt_d        = '0;
            dout_d       = res;
            dout_ovf_d   = res_ovf;
            dout_valid_d = 1'b1;
         end else begin
            state_d = ACC;
            acc_d   = sum;
            cnt_d   = cnt_q + P_NW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         n_lat_q      <= '0;
         shift_lat_q  <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         dout_ovf_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         n_lat_q      <= n_lat_d;
         shift_lat_q  <= shift_lat_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_ovf_q   <= dout_ovf_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign dout_ovf   = dout_ovf_q;

endmodule
